// File: rtl/alu_op_sched.sv
// -----------------------------------------------------------------------------
// alu_op_sched
// Round-robin scheduler that shares one combinational ALU result mux among
// NREQ requesters. Each granted request has its op index translated into the
// 4-bit mux select {S0,S1,S2,S3}. The scheduler drives registered operands,
// waits ALU_LAT cycles for the mux to settle, then returns the captured result
// tagged with the requester id. Op indices 11..15 are rejected with resp_err.
//
// Optional build macro: ALU_SCHED_STATS_EN
//   Adds saturating 16-bit counters stat_ops (good responses) and stat_errs
//   (error responses). Both counters clear on rst.
// -----------------------------------------------------------------------------
module alu_op_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [4*NREQ-1:0]        req_op,
  input  logic [W*NREQ-1:0]        req_a,
  input  logic [W*NREQ-1:0]        req_b,
  output logic [NREQ-1:0]          grant,
  output logic [3:0]               sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  input  logic [W-1:0]             alu_result,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_data,
  output logic                     resp_err,
  output logic                     busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_ops,
  output logic [15:0]              stat_errs
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;       // last granted requester; search starts above it
  logic [IDW-1:0] cur_id;
  logic           cur_err;
  logic [2:0]     cnt;       // settle-time counter while in ISSUE
  logic [W-1:0]   res_q;     // result captured at the end of the settle window

  logic           any_req;
  logic [IDW-1:0] pick_id;
  logic [3:0]     pick_op;
  logic           pick_valid;
  int             arb_idx;

  // Op index to ALU mux select; sel[3] is S0, sel[0] is S3.
  function automatic logic [3:0] op_to_sel(input logic [3:0] op);
    case (op)
      4'd0:    op_to_sel = 4'b0000;
      4'd1:    op_to_sel = 4'b0001;
      4'd2:    op_to_sel = 4'b0011;
      4'd3:    op_to_sel = 4'b1000;
      4'd4:    op_to_sel = 4'b1001;
      4'd5:    op_to_sel = 4'b1010;
      4'd6:    op_to_sel = 4'b1011;
      4'd7:    op_to_sel = 4'b1100;
      4'd8:    op_to_sel = 4'b1101;
      4'd9:    op_to_sel = 4'b1110;
      4'd10:   op_to_sel = 4'b1111;
      default: op_to_sel = 4'b0000;
    endcase
  endfunction

  // Round-robin pick: first asserted request searching upward from ptr+1.
  // Scanning from the farthest candidate down lets the nearest one win last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_req = 1'b0;
    pick_id = '0;
    arb_idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      arb_idx = int'(ptr) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (req[arb_idx]) begin
        any_req = 1'b1;
        pick_id = IDW'(arb_idx);
      end
    end
    pick_op    = req_op[int'(pick_id)*4 +: 4];
    pick_valid = (pick_op <= 4'd10);
  end

  assign busy = (state != IDLE);

  // Scheduler FSM: arbitrate, issue to the ALU, hold for ALU_LAT, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      cur_id     <= '0;
      cur_err    <= 1'b0;
      cnt        <= '0;
      res_q      <= '0;
      grant      <= '0;
      sel        <= 4'b0000;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      grant      <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= NREQ'(1) << pick_id;
            cur_id <= pick_id;
            ptr    <= pick_id;
            cnt    <= '0;
            if (pick_valid) begin
              sel     <= op_to_sel(pick_op);
              alu_a   <= req_a[int'(pick_id)*W +: W];
              alu_b   <= req_b[int'(pick_id)*W +: W];
              cur_err <= 1'b0;
              state   <= ISSUE;
            end else begin
              // Rejected op: the ALU inputs keep their previous values.
              cur_err <= 1'b1;
              state   <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt == 3'(ALU_LAT - 1)) begin
            res_q <= alu_result;
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_id    <= cur_id;
          resp_err   <= cur_err;
          resp_data  <= cur_err ? '0 : res_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Saturating response counters, updated on the edge that raises resp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (state == RESP) begin
      if (cur_err) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sched
// Two schedulers share clk/rst: u_dut0 (ALU_LAT=1) is driven by a behavioural
// ALU built from its own sel/alu_a/alu_b; u_dut1 (ALU_LAT=3) has alu_result
// driven directly so the value can change during the hold window.
// Build with +define+ALU_SCHED_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_alu_op_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT0 ----------------
  logic [NREQ-1:0]   req0;
  logic [3:0]        op_v [NREQ];
  logic [W-1:0]      a_v  [NREQ];
  logic [W-1:0]      b_v  [NREQ];
  logic [4*NREQ-1:0] req_op0;
  logic [W*NREQ-1:0] req_a0, req_b0;
  logic [NREQ-1:0]   grant0;
  logic [3:0]        sel0;
  logic [W-1:0]      alu_a0, alu_b0, alu_res0, resp_data0;
  logic              resp_valid0, resp_err0, busy0;
  logic [1:0]        resp_id0;
  logic [15:0]       st_ops0, st_errs0;

  // ---------------- DUT1 ----------------
  logic [NREQ-1:0]   req1;
  logic [4*NREQ-1:0] req_op1;
  logic [W*NREQ-1:0] req_a1, req_b1;
  logic [NREQ-1:0]   grant1;
  logic [3:0]        sel1;
  logic [W-1:0]      alu_a1, alu_b1, alu_res1, resp_data1;
  logic              resp_valid1, resp_err1, busy1;
  logic [1:0]        resp_id1;
  logic [15:0]       st_ops1, st_errs1;

  // Reference model state for DUT0
  int          last0;
  logic [3:0]  m_sel;
  logic [W-1:0] m_a, m_b;
  int          exp_ops, exp_errs;

  // Spec op table: index -> {S0,S1,S2,S3}
  function automatic logic [3:0] op_code(input int op);
    case (op)
      0: return 4'b0000;  1: return 4'b0001;  2: return 4'b0011;
      3: return 4'b1000;  4: return 4'b1001;  5: return 4'b1010;
      6: return 4'b1011;  7: return 4'b1100;  8: return 4'b1101;
      9: return 4'b1110;  10: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Behavioural ALU mux: one distinct function per select code.
  function automatic logic [W-1:0] alu_env(input logic [3:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (s)
      4'b0000: return a;
      4'b0001: return a & b;
      4'b0011: return a + b;
      4'b1000: return a - b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~a;
      4'b1100: return b;
      4'b1101: return a + 8'd1;
      4'b1110: return b - 8'd1;
      4'b1111: return {a[3:0], b[3:0]};
      default: return '0;
    endcase
  endfunction

  // Round-robin rule: nearest asserted requester above the last winner.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always_comb begin
    req_op0 = '0;
    req_a0  = '0;
    req_b0  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op0[4*i +: 4] = op_v[i];
      req_a0[W*i +: W]  = a_v[i];
      req_b0[W*i +: W]  = b_v[i];
    end
  end

  assign alu_res0 = alu_env(sel0, alu_a0, alu_b0);

  alu_op_sched #(.NREQ(NREQ), .W(W), .ALU_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_op(req_op0), .req_a(req_a0), .req_b(req_b0),
    .grant(grant0), .sel(sel0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_result(alu_res0),
    .resp_valid(resp_valid0), .resp_id(resp_id0), .resp_data(resp_data0),
    .resp_err(resp_err0), .busy(busy0)
`ifdef ALU_SCHED_STATS_EN
    , .stat_ops(st_ops0), .stat_errs(st_errs0)
`endif
  );

  alu_op_sched #(.NREQ(NREQ), .W(W), .ALU_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_op(req_op1), .req_a(req_a1), .req_b(req_b1),
    .grant(grant1), .sel(sel1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_result(alu_res1),
    .resp_valid(resp_valid1), .resp_id(resp_id1), .resp_data(resp_data1),
    .resp_err(resp_err1), .busy(busy1)
`ifdef ALU_SCHED_STATS_EN
    , .stat_ops(st_ops1), .stat_errs(st_errs1)
`endif
  );

`ifndef ALU_SCHED_STATS_EN
  assign st_ops0 = '0; assign st_errs0 = '0;
  assign st_ops1 = '0; assign st_errs1 = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last0 = NREQ - 1;
    m_sel = '0; m_a = '0; m_b = '0;
    exp_ops = 0; exp_errs = 0;
  endtask

  // One DUT0 transaction predicted by the model. mode: 0 keep req,
  // 1 drop the winner's req after grant, 2 drop all reqs after grant.
  task automatic do_txn(input int mode);
    int exp_id, exp_lat, lat;
    bit seen;
    logic [3:0] op, exp_sel, eg;
    logic [W-1:0] a, b, exp_a, exp_b, exp_data;
    logic exp_err;
    exp_id = pick(req0, last0);
    op = op_v[exp_id]; a = a_v[exp_id]; b = b_v[exp_id];
    exp_err = (op > 4'd10);
    if (exp_err) begin
      exp_sel = m_sel; exp_a = m_a; exp_b = m_b; exp_lat = 1; exp_data = '0;
    end else begin
      exp_sel = op_code(int'(op)); exp_a = a; exp_b = b; exp_lat = LAT0 + 1;
      exp_data = alu_env(exp_sel, a, b);
    end
    eg = 4'b0001 << exp_id;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = (grant0 != '0);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL grant_timeout: grant=%b required %b", grant0, eg);
      return;
    end
    n_checks++;
    if (grant0 !== eg) begin
      n_fail++; $display("FAIL grant: got %b required %b", grant0, eg);
    end
    n_checks++;
    if ({sel0, alu_a0, alu_b0} !== {exp_sel, exp_a, exp_b}) begin
      n_fail++;
      $display("FAIL alu_drive: sel/a/b got %b/%h/%h required %b/%h/%h",
               sel0, alu_a0, alu_b0, exp_sel, exp_a, exp_b);
    end
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL busy: got %b required 1", busy0);
    end
    last0 = exp_id; m_sel = exp_sel; m_a = exp_a; m_b = exp_b;
    if (mode == 1) req0[exp_id] = 1'b0;
    else if (mode == 2) req0 = '0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      seen = resp_valid0;
    end
    n_checks++;
    if (lat != exp_lat || !seen) begin
      n_fail++; $display("FAIL latency: got %0d cycles required %0d", lat, exp_lat);
      return;
    end
    n_checks++;
    if ({resp_id0, resp_data0, resp_err0} !== {2'(exp_id), exp_data, exp_err}) begin
      n_fail++;
      $display("FAIL response: id/data/err got %0d/%h/%b required %0d/%h/%b",
               resp_id0, resp_data0, resp_err0, exp_id, exp_data, exp_err);
    end
    if (exp_err) exp_errs++; else exp_ops++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = '0; req1 = '0; req_op1 = '0; req_a1 = '0; req_b1 = '0; alu_res1 = '0;
    for (int i = 0; i < NREQ; i++) begin op_v[i] = '0; a_v[i] = '0; b_v[i] = '0; end
    tick();
    n_checks++;
    if ({grant0, sel0, alu_a0, alu_b0, resp_valid0, resp_id0, resp_data0, resp_err0, busy0} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: grant=%b sel=%b a=%h b=%h rv=%b id=%0d d=%h err=%b busy=%b required all zero",
               grant0, sel0, alu_a0, alu_b0, resp_valid0, resp_id0, resp_data0, resp_err0, busy0);
    end
    n_checks++;
    if ({grant1, sel1, resp_valid1, busy1} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut1: grant=%b sel=%b rv=%b busy=%b required all zero",
               grant1, sel1, resp_valid1, busy1);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    req0 = 4'b0001; op_v[0] = 4'd2; a_v[0] = 8'h12; b_v[0] = 8'h34;
    do_txn(2);
    n_checks++;
    if (resp_data0 !== 8'h46) begin
      n_fail++; $display("FAIL basic_data: got %h required 46", resp_data0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req0 = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      op_v[i] = 4'd3; a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
    end
    for (int n = 0; n < 5; n++) do_txn(n == 4 ? 2 : 0);
  endtask

  task automatic test_invalid();
    req0 = 4'b0100; op_v[2] = 4'd12; a_v[2] = 8'($urandom); b_v[2] = 8'($urandom);
    do_txn(2);
  endtask

  task automatic test_sweep();
    for (int op = 0; op <= 10; op++) begin
      req0 = 4'b0010; op_v[1] = 4'(op); a_v[1] = 8'($urandom); b_v[1] = 8'($urandom);
      do_txn(2);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      req0 = req0 | 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        op_v[i] = 4'($urandom_range(0, 15));
        a_v[i]  = 8'($urandom);
        b_v[i]  = 8'($urandom);
      end
      do_txn(it == 39 ? 2 : 1);
    end
    tick();
  endtask

  task automatic test_stats();
`ifdef ALU_SCHED_STATS_EN
    n_checks++;
    if (st_ops0 !== 16'(exp_ops) || st_errs0 !== 16'(exp_errs)) begin
      n_fail++;
      $display("FAIL stats: ops/errs got %0d/%0d required %0d/%0d",
               st_ops0, st_errs0, exp_ops, exp_errs);
    end
`endif
  endtask

  task automatic test_long_latency();
    int g;
    bit seen;
    logic [W-1:0] vals [LAT1+1];
    logic [W-1:0] expv;
    req1 = 4'b0001; req_op1 = 16'h000A; req_a1 = 32'h0000_00C3; req_b1 = 32'h0000_005E;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (grant1 != '0); end
    n_checks++;
    if (grant1 !== 4'b0001) begin
      n_fail++; $display("FAIL ll_grant: got %b required 0001", grant1);
      return;
    end
    req1 = '0;
    for (int c = 0; c <= LAT1; c++) vals[c] = 8'($urandom);
    // The captured value is whatever alu_result holds on the last hold edge.
    expv = vals[LAT1-1];
    g = 0;
    for (int c = 0; c <= LAT1; c++) begin
      alu_res1 = vals[c];
      if (c < LAT1) begin
        n_checks++;
        if (sel1 !== 4'b1111) begin
          n_fail++; $display("FAIL ll_sel_hold: cycle %0d sel %b required 1111", c, sel1);
        end
      end
      if (resp_valid1) g++;
      tick();
    end
    n_checks++;
    if (g != 0 || resp_valid1 !== 1'b1 || resp_data1 !== expv || resp_err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ll_resp: early=%0d rv=%b data=%h err=%b required 0/1/%h/0",
               g, resp_valid1, resp_data1, resp_err1, expv);
    end
  endtask

  task automatic test_reset_issue();
    bit seen;
    int spurious;
    req1 = 4'b0001; req_op1 = 16'h0006; alu_res1 = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (grant1 != '0); end
    rst = 1'b1;
    req1 = '0;
    #1;
    n_checks++;
    if (busy1 !== 1'b0 || sel1 !== 4'b0000 || resp_valid1 !== 1'b0 || !seen) begin
      n_fail++;
      $display("FAIL rst_issue: granted=%b busy=%b sel=%b rv=%b required 1/0/0000/0",
               seen, busy1, sel1, resp_valid1);
    end
    tick();
    rst = 1'b0;
    last0 = NREQ - 1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (resp_valid1) spurious++; end
    n_checks++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL rst_no_resp: %0d responses required 0", spurious);
    end
    req1 = 4'b0010; req_op1 = 16'h0050; req_a1 = 32'h0000_3C00; req_b1 = 32'h0000_A500;
    alu_res1 = 8'h99;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = (grant1 != '0); end
    n_checks++;
    if (grant1 !== 4'b0010 || sel1 !== 4'b1010 || alu_a1 !== 8'h3C || alu_b1 !== 8'hA5) begin
      n_fail++;
      $display("FAIL rst_regrant: grant=%b sel=%b a=%h b=%h required 0010/1010/3c/a5",
               grant1, sel1, alu_a1, alu_b1);
    end
    req1 = '0;
    for (int i = 0; i < LAT1 + 1; i++) tick();
    n_checks++;
    if (resp_valid1 !== 1'b1 || resp_id1 !== 2'd1 || resp_data1 !== 8'h99) begin
      n_fail++;
      $display("FAIL rst_regrant_resp: rv=%b id=%0d data=%h required 1/1/99",
               resp_valid1, resp_id1, resp_data1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_invalid();
    test_sweep();
    test_random();
    test_stats();
    test_long_latency();
    test_reset_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
